layer_write_arbiter: RTL
========================

// Module: layer_write_arbiter
// PURPOSE
//  Shares the background and food-layer RAM write ports between NUM_REQ game-logic requesters.
//  Commits writes only inside a per-frame update window that opens on the frame-start pulse
//  (the refresh_image pulse, already resynchronised into clk). Round-robin arbitration, one
//  write per two cycles. Sits between the game logic and the tile-layer generators.
// PARAMETERS
//  NUM_REQ       4    number of requesters (2..8)
//  WINDOW_CYCLES 256  clk cycles the window stays open after frame_start (>=2, fits 12 bits)
// PORTS
//  clk                   in   1         single clock; all logic on rising edge
//  reset_n               in   1         reset, synchronous, active-low
//  frame_start           in   1         1-cycle pulse per frame; opens/reloads window
//  req                   in   NUM_REQ   write request per requester, held until gnt
//  req_layer             in   NUM_REQ   target per requester: 0 background, 1 food layer
//  req_addr              in   4*NUM_REQ word address, requester i at [4i+3:4i]
//  req_data              in   32*NUM_REQ write data, requester i at [32i+31:32i]
//  gnt                   out  NUM_REQ   1-cycle grant pulse, coincident with the RAM write
//  background_data       out  32        background RAM write data
//  background_wraddress  out  4         background RAM write address
//  background_wren       out  1         background RAM write strobe
//  food_layer_data       out  32        food-layer RAM write data
//  food_layer_wraddress  out  4         food-layer RAM write address
//  food_layer_wren       out  1         food-layer RAM write strobe
//  window_open           out  1         high while the FSM is in ARB or WRITE
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; win_cnt 0; rr_last = NUM_REQ-1, so req[0] wins first.
//  - FSM IDLE: wait for frame_start, then load win_cnt=WINDOW_CYCLES-1 and go to ARB.
//  - FSM ARB: if win_cnt==0, go to IDLE. Otherwise, if any req is set, pick the first set
//    bit after rr_last (cyclic), latch idx/layer/addr/data and go to WRITE. If no req, stay.
//  - FSM WRITE: for exactly one cycle, assert gnt[idx] and the wren of the latched layer with
//    the latched addr/data. The other layer's wren stays 0. Set rr_last=idx. Go to ARB, or to
//    IDLE if win_cnt==0.
//  - win_cnt decrements by 1 every cycle in ARB or WRITE and saturates at 0.
//  - Timing: req sampled in ARB cycle N gives gnt/wren in cycle N+1. The next arbitration is
//    at N+2. At most ceil(WINDOW_CYCLES/2) writes per window.
//  - Handshake: requester holds req/layer/addr/data stable until it sees gnt. It drops req the
//    cycle after gnt. If it re-raises req, it gets the lowest round-robin priority.
//  - data/wraddress outputs are registered and hold their last value. Only wren qualifies them.
//  - frame_start in ARB/WRITE: reload win_cnt (window extends), no state change, no lost write.
//  - frame_start in the same cycle win_cnt hits 0: reload wins, window stays open.
//  - A write already latched into WRITE always completes, even if the window expires.
//  - req that drops before gnt: ignored if not yet latched. If already latched, the write still
//    commits.
//  - reset_n low mid-write: next edge clears wren/gnt. The write in that cycle is not
//    guaranteed.
// CONFIGURATION
//  LAYER_ARB_STATS_EN defined: adds outputs write_count[7:0] and starved[NUM_REQ-1:0].
//    - write_count: writes committed in the last window, saturating at 255, latched on the
//      ARB/WRITE->IDLE transition.
//    - starved: req bits still high at window close, latched on the same transition.
//    - Both reset to 0.
//  LAYER_ARB_STATS_EN undefined: neither the ports nor the counters exist. Behaviour is
//  otherwise identical.
// TESTING
//  1. Reset, then frame_start with req=0001, layer0=0, addr=3, data=32'hDEADBEEF:
//     2 cycles after the pulse, background_wren=1, wraddress=3, data=DEADBEEF, gnt=0001;
//     food_layer_wren=0.
//  2. req=1111 held (each drops after its gnt): grants 0001,0010,0100,1000 on alternate
//     cycles, no gaps, no repeats.
//  3. WINDOW_CYCLES=4, req=0011 continuous: exactly 2 writes. window_open falls 4 cycles after
//     entering ARB. A third request waits for the next frame_start.
//  4. req raised while IDLE with no frame_start: no wren for 1000 cycles. frame_start then
//     grants it at +2.
//  5. reset_n low for 1 cycle during WRITE: wren, gnt and window_open are 0 on the next edge.
//     A fresh frame_start grants req[0] first.
//  6. (LAYER_ARB_STATS_EN) WINDOW_CYCLES=4, req=0111 held: write_count=2, starved=0100 after
//     close.

Source files
------------

// File: rtl/layer_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : layer_write_arbiter
//  Purpose  : Round-robin arbiter that shares the background and food-layer
//             RAM write ports among NUM_REQ game-logic requesters. Writes are
//             committed only inside an update window that opens on the
//             per-frame frame_start pulse. At most one write every two cycles.
//  Ports    : clk, reset_n (sync, active-low), frame_start (window open/reload)
//             req/req_layer/req_addr/req_data : per-requester write request
//             gnt                             : 1-cycle grant, with the write
//             background_* / food_layer_*     : registered RAM write ports
//             window_open                     : high in ARB or WRITE
//             write_count, starved            : only with LAYER_ARB_STATS_EN
//  Options  : LAYER_ARB_STATS_EN adds per-window write count and starvation
//             outputs, latched when the window closes.
//  Revision : 1.0  initial release
// ============================================================================
module layer_write_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int WINDOW_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    frame_start,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_layer,
  input  logic [4*NUM_REQ-1:0]    req_addr,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [31:0]             background_data,
  output logic [3:0]              background_wraddress,
  output logic                    background_wren,
  output logic [31:0]             food_layer_data,
  output logic [3:0]              food_layer_wraddress,
  output logic                    food_layer_wren,
  output logic                    window_open
`ifdef LAYER_ARB_STATS_EN
  ,
  output logic [7:0]              write_count,
  output logic [NUM_REQ-1:0]      starved
`endif
);

  localparam int          IDX_W      = $clog2(NUM_REQ);
  localparam logic [11:0] C_WIN_LOAD = 12'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [11:0]        r_win_cnt;
  logic [IDX_W-1:0]   r_rr_last;
  logic [IDX_W-1:0]   r_idx;
  logic               w_pick_valid;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_expired;

  // A frame_start arriving as the counter hits zero reloads the window
  // instead of letting it close.
  assign w_expired   = (r_win_cnt == 12'd0) && !frame_start;
  assign window_open = (r_state == S_ARB) || (r_state == S_WRITE);

  // Cyclic search starting just after the last granted requester.
  always_comb begin
    int j;
    j            = 0;
    w_pick_valid = 1'b0;
    w_pick_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(r_rr_last) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_pick_valid && req[j]) begin
        w_pick_valid = 1'b1;
        w_pick_idx   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (frame_start) w_state_next = S_ARB;
      S_ARB: begin
        if (w_expired)         w_state_next = S_IDLE;
        else if (w_pick_valid) w_state_next = S_WRITE;
      end
      S_WRITE: w_state_next = w_expired ? S_IDLE : S_ARB;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Write-port outputs are loaded on the ARB->WRITE edge so that they are
  // visible for exactly the WRITE cycle; data/address hold afterwards.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state              <= S_IDLE;
      r_win_cnt            <= 12'd0;
      r_rr_last            <= IDX_W'(NUM_REQ - 1);
      r_idx                <= '0;
      gnt                  <= '0;
      background_data      <= 32'd0;
      background_wraddress <= 4'd0;
      background_wren      <= 1'b0;
      food_layer_data      <= 32'd0;
      food_layer_wraddress <= 4'd0;
      food_layer_wren      <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (frame_start)
        r_win_cnt <= C_WIN_LOAD;
      else if (r_state != S_IDLE && r_win_cnt != 12'd0)
        r_win_cnt <= r_win_cnt - 12'd1;

      gnt             <= '0;
      background_wren <= 1'b0;
      food_layer_wren <= 1'b0;

      if (r_state == S_ARB && w_state_next == S_WRITE) begin
        r_idx <= w_pick_idx;
        gnt   <= NUM_REQ'(1) << w_pick_idx;
        if (req_layer[w_pick_idx]) begin
          food_layer_data      <= req_data[32*w_pick_idx +: 32];
          food_layer_wraddress <= req_addr[4*w_pick_idx +: 4];
          food_layer_wren      <= 1'b1;
        end else begin
          background_data      <= req_data[32*w_pick_idx +: 32];
          background_wraddress <= req_addr[4*w_pick_idx +: 4];
          background_wren      <= 1'b1;
        end
      end

      if (r_state == S_WRITE)
        r_rr_last <= r_idx;
    end
  end

`ifdef LAYER_ARB_STATS_EN
  logic [7:0] r_win_writes;
  logic       w_closing;

  assign w_closing = (r_state != S_IDLE) && (w_state_next == S_IDLE);

  // A window closing out of WRITE includes that final write; the requester
  // being granted in that cycle is not counted as starved.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_win_writes <= 8'd0;
      write_count  <= 8'd0;
      starved      <= '0;
    end else if (w_closing) begin
      write_count  <= (r_state == S_WRITE && r_win_writes != 8'hFF)
                      ? r_win_writes + 8'd1 : r_win_writes;
      starved      <= req & ~gnt;
      r_win_writes <= 8'd0;
    end else if (r_state == S_WRITE && r_win_writes != 8'hFF) begin
      r_win_writes <= r_win_writes + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire
